// File: rtl/i2c_apb_master.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS transfers
// against the I2C controller register block, with a PREADY wait timeout.
module i2c_apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK_i,
  input  logic              PRESET_i,
  input  logic              REQ_VALID_i,
  output logic              REQ_READY_o,
  input  logic              REQ_WRITE_i,
  input  logic [ADDR_W-1:0] REQ_ADDR_i,
  input  logic [DATA_W-1:0] REQ_WDATA_i,
  output logic              RSP_VALID_o,
  output logic [DATA_W-1:0] RSP_RDATA_o,
  output logic              RSP_ERR_o,
  output logic              BUSY_o,
  output logic [1:0]        DBG_STATE_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  output logic              PWRITE_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i
);

  // Handshake: a request is taken on the rising edge where REQ_VALID_i and
  // REQ_READY_o are both 1; REQ_READY_o is high only in IDLE. RSP_VALID_o is a
  // one-cycle pulse with no back-pressure, and RSP_RDATA_o/RSP_ERR_o hold until
  // the next completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  assign DBG_STATE_o = state;

  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      REQ_READY_o <= 1'b1;
      BUSY_o      <= 1'b0;
      PSEL_o      <= 1'b0;
      PENABLE_o   <= 1'b0;
      PWRITE_o    <= 1'b0;
      PADDR_o     <= '0;
      PWDATA_o    <= '0;
      RSP_VALID_o <= 1'b0;
      RSP_RDATA_o <= '0;
      RSP_ERR_o   <= 1'b0;
    end else begin
      RSP_VALID_o <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID_i && REQ_READY_o) begin
            PWRITE_o    <= REQ_WRITE_i;
            PADDR_o     <= REQ_ADDR_i;
            PWDATA_o    <= REQ_WRITE_i ? REQ_WDATA_i : '0;
            PSEL_o      <= 1'b1;
            REQ_READY_o <= 1'b0;
            BUSY_o      <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt  <= 8'd0;
          PENABLE_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (PREADY_i || (TO_EN && wait_cnt == TO_LAST)) begin
            RSP_RDATA_o <= (PREADY_i && !PWRITE_o) ? PRDATA_i : '0;
            RSP_ERR_o   <= !PREADY_i;
            RSP_VALID_o <= 1'b1;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            REQ_READY_o <= 1'b1;
            BUSY_o      <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          PSEL_o      <= 1'b0;
          PENABLE_o   <= 1'b0;
          REQ_READY_o <= 1'b1;
          BUSY_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_master.sv
// Bench for i2c_apb_master: register-block model on the APB side, randomized
// requests, scoreboard of expected {latency, err, rdata} per transfer.
module tb_i2c_apb_master;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       PRESET_i = 1'b0;
  logic       REQ_VALID_i = 1'b0;
  logic       REQ_WRITE_i = 1'b0;
  logic [7:0] REQ_ADDR_i = 8'd0;
  logic [7:0] REQ_WDATA_i = 8'd0;
  logic       REQ_READY_o, RSP_VALID_o, RSP_ERR_o, BUSY_o;
  logic [7:0] RSP_RDATA_o;
  logic [1:0] DBG_STATE_o;
  logic       PSEL_o, PENABLE_o, PWRITE_o;
  logic [7:0] PADDR_o, PWDATA_o, PRDATA_i;
  logic       PREADY_i;

  i2c_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .PCLK_i(clk), .PRESET_i(PRESET_i),
    .REQ_VALID_i(REQ_VALID_i), .REQ_READY_o(REQ_READY_o), .REQ_WRITE_i(REQ_WRITE_i),
    .REQ_ADDR_i(REQ_ADDR_i), .REQ_WDATA_i(REQ_WDATA_i),
    .RSP_VALID_o(RSP_VALID_o), .RSP_RDATA_o(RSP_RDATA_o), .RSP_ERR_o(RSP_ERR_o),
    .BUSY_o(BUSY_o), .DBG_STATE_o(DBG_STATE_o),
    .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
    .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];   // {latency[7:0], err, rdata[7:0]}
  int          acc_q[$];
  int          acc_all[$];
  int          wait_q[$];  // per-transfer PREADY delay; -1 = never ready
  int          cyc = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endfunction

  function automatic bit writable(input logic [7:0] a);
    return (a == 8'h00) || (a == 8'h01) || (a == 8'h02) || (a == 8'h04);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] ref_mem[256];

  // ---------------- register block on the APB side ----------------
  logic [7:0] slv_mem[256];
  int         cur_wait = 0;
  int         acc_cnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  assign PRDATA_i = slv_mem[PADDR_o];

  always @(posedge clk or posedge PRESET_i) begin
    if (PRESET_i) begin
      PREADY_i <= 1'b0;
      acc_cnt  <= 0;
    end else begin
      if (PSEL_o && !PENABLE_o)
        cur_wait <= (wait_q.size() != 0) ? wait_q.pop_front() : 0;
      if (PSEL_o && PENABLE_o) begin
        if (PREADY_i && PWRITE_o && writable(PADDR_o)) slv_mem[PADDR_o] <= PWDATA_o;
        acc_cnt  <= acc_cnt + 1;
        PREADY_i <= (cur_wait >= 0) && (acc_cnt >= cur_wait);
      end else begin
        acc_cnt  <= 0;
        PREADY_i <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (PRESET_i) begin
      acc_q.delete();
    end else begin
      cyc++;
      if (REQ_VALID_i && REQ_READY_o) begin
        acc_q.push_back(cyc);
        acc_all.push_back(cyc);
      end
      if (RSP_VALID_o === 1'b1) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (rdata 0x%0h)", RSP_RDATA_o);
        end else begin
          logic [16:0] e;
          int          a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_rdata", RSP_RDATA_o, e[7:0]);
          chk("rsp_err", RSP_ERR_o, e[8]);
          chk("rsp_latency", cyc - a, e[16:9]);
          chk("psel_low_at_rsp", PSEL_o, 1'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (REQ_READY_o) break;
    end
    if (k == 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: got ready=0 expected ready=1 within 300 cycles", nm);
    end else begin
      @(posedge clk);
      #1;
    end
    REQ_VALID_i = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d, input int ew);
    logic [7:0] rd;
    logic       er;
    int         lat;
    if (ew < 0) begin
      er = 1'b1; rd = 8'h00; lat = TO + 2;
    end else begin
      er = 1'b0; lat = 4 + ew;
      if (w) begin
        rd = 8'h00;
        if (writable(a)) ref_mem[a] = d;
      end else begin
        rd = ref_mem[a];
      end
    end
    exp_q.push_back({8'(lat), er, rd});
    wait_q.push_back(ew);
    REQ_VALID_i = 1'b1;
    REQ_WRITE_i = w;
    REQ_ADDR_i  = a;
    REQ_WDATA_i = d;
    wait_accept("req");
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (k == 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    #1 PRESET_i = 1'b1;
    #1;
    chk("rst_psel", PSEL_o, 0);
    chk("rst_penable", PENABLE_o, 0);
    chk("rst_pwrite", PWRITE_o, 0);
    chk("rst_paddr", PADDR_o, 0);
    chk("rst_pwdata", PWDATA_o, 0);
    chk("rst_rsp_valid", RSP_VALID_o, 0);
    chk("rst_rsp_rdata", RSP_RDATA_o, 0);
    chk("rst_rsp_err", RSP_ERR_o, 0);
    chk("rst_busy", BUSY_o, 0);
    chk("rst_req_ready", REQ_READY_o, 1);
    repeat (2) @(posedge clk);
    #1 PRESET_i = 1'b0;
    chk("post_rst_ready", REQ_READY_o, 1);
    chk("post_rst_psel", PSEL_o, 0);

    // write/readback of host-writable registers
    do_req(1, 8'h00, 8'h2A, 0); do_req(0, 8'h00, 8'h00, 0);
    do_req(1, 8'h01, 8'h5C, 0); do_req(0, 8'h01, 8'h00, 0);
    do_req(1, 8'h04, 8'hA7, 0); do_req(0, 8'h04, 8'h00, 0);
    // registers the host cannot write
    do_req(1, 8'h03, 8'h55, 0); do_req(0, 8'h03, 8'h00, 0);
    do_req(0, 8'h05, 8'h00, 0);
    wait_idle();

    // PREADY never rises: timeout after TO ACCESS cycles
    do_req(0, 8'h01, 8'h00, -1);
    wait_idle();

    // back-to-back writes with REQ_VALID_i held high
    base = acc_all.size();
    do_req(1, 8'h00, 8'h11, 0);
    do_req(1, 8'h01, 8'h22, 0);
    do_req(1, 8'h04, 8'h33, 0);
    wait_idle();
    if (acc_all.size() >= base + 3) begin
      chk("b2b_gap1", acc_all[base+1] - acc_all[base], 4);
      chk("b2b_gap2", acc_all[base+2] - acc_all[base+1], 4);
    end else begin
      chk("b2b_accepts", acc_all.size() - base, 3);
    end
    do_req(0, 8'h00, 8'h00, 0);
    do_req(0, 8'h01, 8'h00, 0);
    do_req(0, 8'h04, 8'h00, 0);
    wait_idle();

    // reset in the second ACCESS cycle of a write: aborted, register unchanged
    wait_q.push_back(3);
    REQ_VALID_i = 1'b1; REQ_WRITE_i = 1'b1; REQ_ADDR_i = 8'h00; REQ_WDATA_i = 8'hEE;
    wait_accept("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_busy", BUSY_o, 1);
    chk("mid_penable", PENABLE_o, 1);
    #2 PRESET_i = 1'b1;
    #1;
    chk("mid_rst_psel", PSEL_o, 0);
    chk("mid_rst_penable", PENABLE_o, 0);
    chk("mid_rst_busy", BUSY_o, 0);
    repeat (2) @(posedge clk);
    #1 PRESET_i = 1'b0;
    chk("mid_rst_ready", REQ_READY_o, 1);
    do_req(0, 8'h00, 8'h00, 0);
    wait_idle();

    // randomized traffic with random PREADY delays and occasional hangs
    for (int i = 0; i < 40; i++) begin
      int ew;
      int gap;
      ew = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), ew);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
